// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared codes and types for the two-player 3x3 game turn controller
package game_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P1    = 2'b01;
   localparam logic [1:0] CELL_P2    = 2'b10;

   localparam logic [1:0] PLAYER_NONE = 2'b00;
   localparam logic [1:0] PLAYER_1    = 2'b01;
   localparam logic [1:0] PLAYER_2    = 2'b10;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TURN_P1,
      ST_TURN_P2,
      ST_CHECK,
      ST_DONE
   } state_t;

   typedef logic [3:1][3:1][1:0] board_t;

endpackage

// File: rtl/game_turn_controller_timer.sv
// rtl/game_turn_controller_timer.sv - per-turn tick counter and saturating seconds countdown
module turn_timer #(
   parameter int TICKS_PER_SEC = 50000000,
   parameter int TURN_SECONDS  = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       run,
   output logic [3:0] seconds_left,
   output logic       expired
);

   localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TW-1:0] TICK_MAX  = TW'(TICKS_PER_SEC - 1);
   localparam logic [3:0]    SECS_INIT = 4'(TURN_SECONDS);

   logic [TW-1:0] tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick         <= '0;
         seconds_left <= '0;
      end else if (load) begin
         tick         <= '0;
         seconds_left <= SECS_INIT;
      end else if (run) begin
         if (tick == TICK_MAX) begin
            tick <= '0;
            if (seconds_left != 4'd0)
               seconds_left <= seconds_left - 4'd1;
         end else begin
            tick <= tick + 1'b1;
         end
      end
   end

   assign expired = (seconds_left == 4'd0);

endmodule

// File: rtl/game_turn_controller.sv
// rtl/game_turn_controller.sv - turn sequencing, board ownership, timeout and win/draw detection
module game_turn_controller #(
   parameter int TICKS_PER_SEC = 50000000,
   parameter int TURN_SECONDS  = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   end_attack_p1,
   input  logic                   end_attack_p2,
   input  logic [1:0]             row,
   input  logic [1:0]             col,
   output logic [1:0]             current_player,
   output logic                   en_attack_p1,
   output logic                   en_attack_p2,
   output logic                   timeout,
   output logic [3:1][3:1][1:0]   board,
   output logic [3:0]             seconds_left,
   output logic [1:0]             winner,
   output logic                   game_over
);

   import game_pkg::*;

   state_t     state, state_next;
   board_t     board_q;
   logic [1:0] mover_q;
   logic       timeout_q;
   logic [1:0] winner_q;

   logic [1:0] active_code, winner_next, line_w;
   logic       target_empty, accept, full;
   logic       timer_load, timer_run, expired, new_game, set_winner, in_turn;

   function automatic logic [1:0] line_winner(input board_t b);
      logic [1:0] w;
      w = WIN_NONE;
      for (int i = 1; i <= 3; i++) begin
         if (b[i][1] != CELL_EMPTY && b[i][1] == b[i][2] && b[i][2] == b[i][3]) w = b[i][1];
         if (b[1][i] != CELL_EMPTY && b[1][i] == b[2][i] && b[2][i] == b[3][i]) w = b[1][i];
      end
      if (b[2][2] != CELL_EMPTY && b[1][1] == b[2][2] && b[2][2] == b[3][3]) w = b[2][2];
      if (b[2][2] != CELL_EMPTY && b[1][3] == b[2][2] && b[2][2] == b[3][1]) w = b[2][2];
      return w;
   endfunction

   function automatic logic board_full(input board_t b);
      logic f;
      f = 1'b1;
      for (int r = 1; r <= 3; r++)
         for (int c = 1; c <= 3; c++)
            if (b[r][c] == CELL_EMPTY) f = 1'b0;
      return f;
   endfunction

   // row/col of 0 never matches a cell, which is how out-of-range coordinates are rejected
   always_comb begin
      target_empty = 1'b0;
      for (int r = 1; r <= 3; r++)
         for (int c = 1; c <= 3; c++)
            if (row == 2'(r) && col == 2'(c) && board_q[r][c] == CELL_EMPTY)
               target_empty = 1'b1;
   end

   always_comb begin
      state_next     = state;
      current_player = PLAYER_NONE;
      en_attack_p1   = 1'b0;
      en_attack_p2   = 1'b0;
      active_code    = CELL_EMPTY;
      accept         = 1'b0;
      new_game       = 1'b0;
      timer_load     = 1'b0;
      timer_run      = 1'b0;
      set_winner     = 1'b0;
      winner_next    = WIN_NONE;
      line_w         = line_winner(board_q);
      full           = board_full(board_q);
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               new_game   = 1'b1;
               timer_load = 1'b1;
               state_next = ST_TURN_P1;
            end
         end
         ST_TURN_P1: begin
            current_player = PLAYER_1;
            en_attack_p1   = 1'b1;
            active_code    = CELL_P1;
            accept         = end_attack_p1 && target_empty;
            timer_run      = !timeout_q && !accept;
            if (accept) state_next = ST_CHECK;
         end
         ST_TURN_P2: begin
            current_player = PLAYER_2;
            en_attack_p2   = 1'b1;
            active_code    = CELL_P2;
            accept         = end_attack_p2 && target_empty;
            timer_run      = !timeout_q && !accept;
            if (accept) state_next = ST_CHECK;
         end
         ST_CHECK: begin
            if (line_w != WIN_NONE) begin
               set_winner  = 1'b1;
               winner_next = line_w;
               state_next  = ST_DONE;
            end else if (full) begin
               set_winner  = 1'b1;
               winner_next = WIN_DRAW;
               state_next  = ST_DONE;
            end else begin
               timer_load = 1'b1;
               state_next = (mover_q == PLAYER_1) ? ST_TURN_P2 : ST_TURN_P1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign in_turn = (state == ST_TURN_P1) || (state == ST_TURN_P2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         mover_q   <= PLAYER_NONE;
         timeout_q <= 1'b0;
         winner_q  <= WIN_NONE;
      end else begin
         state <= state_next;
         if (accept) mover_q <= active_code;
         // a placement on the expiry cycle wins, so timeout never rises for that turn
         if (accept || new_game)
            timeout_q <= 1'b0;
         else if (in_turn && expired)
            timeout_q <= 1'b1;
         if (new_game)
            winner_q <= WIN_NONE;
         else if (set_winner)
            winner_q <= winner_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         board_q <= '0;
      end else if (new_game) begin
         board_q <= '0;
      end else if (accept) begin
         for (int r = 1; r <= 3; r++)
            for (int c = 1; c <= 3; c++)
               if (row == 2'(r) && col == 2'(c))
                  board_q[r][c] <= active_code;
      end
   end

   turn_timer #(
      .TICKS_PER_SEC(TICKS_PER_SEC),
      .TURN_SECONDS (TURN_SECONDS)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .load        (timer_load),
      .run         (timer_run),
      .seconds_left(seconds_left),
      .expired     (expired)
   );

   assign board     = board_q;
   assign timeout   = timeout_q;
   assign winner    = winner_q;
   assign game_over = (state == ST_DONE);

endmodule
